// File: rtl/ex_mdu_pkg.sv
// Shared types for the EX-stage multiply/divide unit: op encoding, FSM states
// and operand forwarding selects.
package ex_mdu_pkg;

   typedef enum logic [2:0] {
      OP_NONE  = 3'd0,
      OP_MULT  = 3'd1,
      OP_MULTU = 3'd2,
      OP_DIV   = 3'd3,
      OP_DIVU  = 3'd4,
      OP_MTHI  = 3'd5,
      OP_MTLO  = 3'd6,
      OP_NONE7 = 3'd7
   } mdu_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2,
      ST_FIN  = 2'd3
   } mdu_state_e;

   localparam logic [1:0] FWD_REG = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/ex_mdu_if.sv
// EX-stage MDU port bundle: issue/forwarding inputs and HI/LO/status outputs.
interface ex_mdu_if #(parameter int unsigned XLEN = 32);

   logic            start_i;
   logic [2:0]      op_i;
   logic [XLEN-1:0] rs_i;
   logic [XLEN-1:0] rt_i;
   logic [XLEN-1:0] mem_data_i;
   logic [XLEN-1:0] wb_data_i;
   logic [1:0]      fwd_a_i;
   logic [1:0]      fwd_b_i;
   logic            flush_i;
   logic            stall_o;
   logic            busy_o;
   logic            done_o;
   logic            div0_o;
   logic [XLEN-1:0] hi_o;
   logic [XLEN-1:0] lo_o;

   modport master (
      output start_i, op_i, rs_i, rt_i, mem_data_i, wb_data_i, fwd_a_i, fwd_b_i, flush_i,
      input  stall_o, busy_o, done_o, div0_o, hi_o, lo_o
   );

   modport slave (
      input  start_i, op_i, rs_i, rt_i, mem_data_i, wb_data_i, fwd_a_i, fwd_b_i, flush_i,
      output stall_o, busy_o, done_o, div0_o, hi_o, lo_o
   );

endinterface

// File: rtl/ex_mdu_div_step.sv
// One restoring-division step: shift in the next dividend bit, subtract the
// divisor when it fits, and emit the quotient bit.
module mdu_div_step #(
   parameter int unsigned XLEN = 32
) (
   input  logic [XLEN-1:0] rem_i,
   input  logic            bit_i,
   input  logic [XLEN-1:0] dvsr_i,
   output logic [XLEN-1:0] rem_o,
   output logic            q_o
);

   logic [XLEN:0] shifted;

   // rem_i < dvsr_i always holds, so the restored remainder fits in XLEN bits
   always_comb begin
      shifted = {rem_i, bit_i};
      q_o     = shifted >= {1'b0, dvsr_i};
      rem_o   = q_o ? XLEN'(shifted - {1'b0, dvsr_i}) : XLEN'(shifted);
   end

endmodule

// File: rtl/ex_mdu.sv
// Iterative signed/unsigned multiply/divide with HI/LO registers and EX-stage
// forwarding. Define EX_MDU_DIV_EN to build the divider datapath.
module ex_mdu
   import ex_mdu_pkg::*;
#(
   parameter int unsigned XLEN = 32,
   parameter int unsigned CW   = 6
) (
   input  logic     clk,
   input  logic     rst,
   ex_mdu_if.slave  bus
);

   localparam int unsigned   W2   = 2 * XLEN;
   localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

   mdu_state_e      state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [W2-1:0]   acc_q, acc_d;
   logic [XLEN-1:0] b_q, b_d, hi_q, hi_d, lo_q, lo_d;
   logic            sa_q, sa_d, sb_q, sb_d, div_q, div_d;

   mdu_op_e         op;
   logic [XLEN-1:0] a, b, a_mag, b_mag;
   logic            a_neg, b_neg, sgn_op, is_mul, is_div, accept, done;
   logic [XLEN:0]   mul_sum;
   logic [W2-1:0]   mul_next, prod;

   // Forwarding muxes and operand magnitudes
   always_comb begin
      case (bus.fwd_a_i)
         FWD_WB:  a = bus.wb_data_i;
         FWD_MEM: a = bus.mem_data_i;
         default: a = bus.rs_i;
      endcase
      case (bus.fwd_b_i)
         FWD_WB:  b = bus.wb_data_i;
         FWD_MEM: b = bus.mem_data_i;
         default: b = bus.rt_i;
      endcase
      op     = mdu_op_e'(bus.op_i);
      is_mul = (op == OP_MULT) || (op == OP_MULTU);
      is_div = (op == OP_DIV)  || (op == OP_DIVU);
      sgn_op = (op == OP_MULT) || (op == OP_DIV);
      a_neg  = sgn_op & a[XLEN-1];
      b_neg  = sgn_op & b[XLEN-1];
      a_mag  = a_neg ? -a : a;
      b_mag  = b_neg ? -b : b;
      accept = (state_q == ST_IDLE) & bus.start_i & ~bus.flush_i;
   end

   // Shift-add step: acc holds {partial product, remaining multiplier bits}
   always_comb begin
      mul_sum  = {1'b0, acc_q[W2-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);
      mul_next = {mul_sum, acc_q[XLEN-1:1]};
      prod     = (sa_q ^ sb_q) ? -acc_q : acc_q;
   end

`ifdef EX_MDU_DIV_EN
   logic [XLEN-1:0] div_rem, quot_s, rem_s;
   logic            div_qbit;
   logic [W2-1:0]   div_next;

   mdu_div_step #(.XLEN(XLEN)) u_div_step (
      .rem_i  (acc_q[W2-1:XLEN]),
      .bit_i  (acc_q[XLEN-1]),
      .dvsr_i (b_q),
      .rem_o  (div_rem),
      .q_o    (div_qbit)
   );

   // acc holds {remainder, unconsumed dividend bits | quotient bits}
   always_comb begin
      div_next = {div_rem, acc_q[XLEN-2:0], div_qbit};
      quot_s   = (sa_q ^ sb_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
      rem_s    = sa_q ? -acc_q[W2-1:XLEN] : acc_q[W2-1:XLEN];
   end
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      b_d     = b_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      sa_d    = sa_q;
      sb_d    = sb_q;
      div_d   = div_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               if (is_mul || is_div) begin
                  cnt_d = '0;
                  acc_d = {{XLEN{1'b0}}, a_mag};
                  b_d   = b_mag;
                  sa_d  = a_neg;
                  sb_d  = b_neg;
                  div_d = is_div;
`ifdef EX_MDU_DIV_EN
                  state_d = is_div ? ST_DIV : ST_MUL;
`else
                  state_d = is_div ? ST_FIN : ST_MUL;
`endif
               end else if (op == OP_MTHI) begin
                  hi_d = a;
               end else if (op == OP_MTLO) begin
                  lo_d = a;
               end
            end
         end
         ST_MUL: begin
            acc_d = mul_next;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == LAST) state_d = ST_FIN;
         end
         ST_DIV: begin
`ifdef EX_MDU_DIV_EN
            acc_d = div_next;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == LAST) state_d = ST_FIN;
`else
            state_d = ST_IDLE;
`endif
         end
         ST_FIN: begin
            state_d = ST_IDLE;
            if (!div_q) begin
               {hi_d, lo_d} = prod;
            end else begin
`ifdef EX_MDU_DIV_EN
               // Divide by zero leaves the dividend in the remainder path
               hi_d = rem_s;
               lo_d = (b_q == '0) ? '1 : quot_s;
`endif
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (bus.flush_i && (state_q != ST_IDLE)) begin
         state_d = ST_IDLE;
         hi_d    = hi_q;
         lo_d    = lo_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         acc_q   <= '0;
         b_q     <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         sa_q    <= 1'b0;
         sb_q    <= 1'b0;
         div_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         b_q     <= b_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         sa_q    <= sa_d;
         sb_q    <= sb_d;
         div_q   <= div_d;
      end
   end

   assign done        = (state_q == ST_FIN) & ~bus.flush_i;
   assign bus.done_o  = done;
   assign bus.busy_o  = state_q != ST_IDLE;
   assign bus.stall_o = (accept & (is_mul | is_div)) | (state_q != ST_IDLE);
   assign bus.hi_o    = hi_q;
   assign bus.lo_o    = lo_q;
`ifdef EX_MDU_DIV_EN
   assign bus.div0_o  = done & div_q & (b_q == '0);
`else
   assign bus.div0_o  = done & div_q;
`endif

endmodule

// File: tb/tb_ex_mdu.sv
// Randomized bench for ex_mdu against an arithmetic HI/LO reference model.
module tb_ex_mdu;

   localparam int unsigned XLEN = 32;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   ex_mdu_if #(.XLEN(XLEN)) bus();

   ex_mdu #(.XLEN(XLEN), .CW(6)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   int          total = 0;
   int          bad   = 0;
   logic [31:0] m_hi  = '0;
   logic [31:0] m_lo  = '0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.start_i    = 1'b0;
      bus.op_i       = 3'd0;
      bus.flush_i    = 1'b0;
      bus.fwd_a_i    = 2'b00;
      bus.fwd_b_i    = 2'b00;
      bus.rs_i       = $urandom;
      bus.rt_i       = $urandom;
      bus.mem_data_i = $urandom;
      bus.wb_data_i  = $urandom;
   endtask

   function automatic logic [31:0] pick_val();
      case ($urandom_range(0, 5))
         0:       return 32'h0000_0000;
         1:       return 32'h0000_0001;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'h8000_0000;
         default: return $urandom;
      endcase
   endfunction

   // Architectural result of one op, from plain integer arithmetic
   task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] hi, output logic [31:0] lo,
                        output logic d0, output int lat);
      longint sa, sb;
      logic [63:0] p;
      int ia, ib;
      hi = m_hi; lo = m_lo; d0 = 1'b0; lat = XLEN + 1;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ia = $signed(a);
      ib = $signed(b);
      case (op)
         3'd1: begin p = 64'(sa * sb); hi = p[63:32]; lo = p[31:0]; end
         3'd2: begin p = {32'd0, a} * {32'd0, b}; hi = p[63:32]; lo = p[31:0]; end
         3'd3, 3'd4: begin
`ifdef EX_MDU_DIV_EN
            if (b == 32'd0) begin
               hi = a; lo = 32'hFFFF_FFFF; d0 = 1'b1;
            end else if (op == 3'd3 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
               hi = 32'd0; lo = 32'h8000_0000;
            end else if (op == 3'd3) begin
               lo = 32'(ia / ib); hi = 32'(ia % ib);
            end else begin
               lo = a / b; hi = a % b;
            end
`else
            d0 = 1'b1; lat = 1;
`endif
         end
         3'd5: begin hi = a; lat = 0; end
         3'd6: begin lo = a; lat = 0; end
         default: lat = 0;
      endcase
   endtask

   task automatic drive_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [1:0] fa, input logic [1:0] fb);
      bus.rs_i       = $urandom;
      bus.rt_i       = $urandom;
      bus.mem_data_i = $urandom;
      bus.wb_data_i  = $urandom;
      case (fa)
         2'b01:   bus.wb_data_i  = a;
         2'b10:   bus.mem_data_i = a;
         default: bus.rs_i       = a;
      endcase
      case (fb)
         2'b01:   bus.wb_data_i  = b;
         2'b10:   bus.mem_data_i = b;
         default: bus.rt_i       = b;
      endcase
      bus.fwd_a_i = fa;
      bus.fwd_b_i = fb;
      bus.op_i    = op;
      bus.start_i = 1'b1;
   endtask

   // Issue one op in the current cycle and check its whole lifetime
   task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [1:0] fa, input logic [1:0] fb);
      logic [31:0] ehi, elo;
      logic        ed0;
      int          lat;
      bit          seen;
      model(op, a, b, ehi, elo, ed0, lat);
      drive_op(op, a, b, fa, fb);
      #1;
      chk({tag, "_stall0"}, bus.stall_o, lat > 0);
      seen = (lat == 0);
      cyc();
      for (int n = 1; n <= 100 && !seen; n++) begin
         if (bus.done_o) begin
            seen = 1'b1;
            chk({tag, "_lat"}, n, lat);
            chk({tag, "_div0"}, bus.div0_o, ed0);
            chk({tag, "_stall_done"}, bus.stall_o, 1'b1);
            bus.start_i = 1'b0;
            cyc();
         end else begin
            // Anything issued while busy must be ignored
            bus.start_i = 1'($urandom_range(0, 1));
            bus.op_i    = 3'($urandom_range(1, 6));
            bus.rs_i    = $urandom;
            cyc();
         end
      end
      if (!seen) chk({tag, "_timeout"}, 1'b0, 1'b1);
      bus.start_i = 1'b0;
      #1;
      chk({tag, "_busy_after"}, {bus.busy_o, bus.stall_o}, 2'b00);
      chk({tag, "_hi"}, bus.hi_o, ehi);
      chk({tag, "_lo"}, bus.lo_o, elo);
      m_hi = ehi;
      m_lo = elo;
   endtask

   initial begin
      logic [2:0]  op;
      logic [1:0]  fa, fb;
      logic [31:0] hi_save;
      bit          got_done;

      idle_inputs();
      rst = 1'b1;
      repeat (3) cyc();
      chk("rst_busy", bus.busy_o, 1'b0);
      chk("rst_done", bus.done_o, 1'b0);
      chk("rst_div0", bus.div0_o, 1'b0);
      chk("rst_stall", bus.stall_o, 1'b0);
      chk("rst_hi", bus.hi_o, 32'd0);
      chk("rst_lo", bus.lo_o, 32'd0);
      rst = 1'b0;
      cyc();

      run_op("mult_tp", 3'd1, 32'hFFFF_FFFE, 32'd3, 2'b00, 2'b00);
      chk("mult_tp_hi_k", bus.hi_o, 32'hFFFF_FFFF);
      chk("mult_tp_lo_k", bus.lo_o, 32'hFFFF_FFFA);
      run_op("multu_tp", 3'd2, 32'hFFFF_FFFE, 32'd3, 2'b01, 2'b10);
      chk("multu_tp_hi_k", bus.hi_o, 32'h0000_0002);
      chk("multu_tp_lo_k", bus.lo_o, 32'hFFFF_FFFA);
      hi_save = bus.hi_o;

      run_op("div_mem", 3'd3, 32'hFFFF_FFF9, 32'd2, 2'b10, 2'b00);
`ifdef EX_MDU_DIV_EN
      chk("div_mem_lo_k", bus.lo_o, 32'hFFFF_FFFD);
      chk("div_mem_hi_k", bus.hi_o, 32'hFFFF_FFFF);
`else
      chk("div_off_hi_k", bus.hi_o, hi_save);
`endif
      run_op("divu_zero", 3'd4, 32'h0000_1234, 32'd0, 2'b00, 2'b01);
`ifdef EX_MDU_DIV_EN
      chk("divu_zero_hi_k", bus.hi_o, 32'h0000_1234);
      chk("divu_zero_lo_k", bus.lo_o, 32'hFFFF_FFFF);
`endif
      run_op("div_ovf", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 2'b00, 2'b00);

      // Flush mid-multiply: no write, no done
      run_op("mtlo", 3'd6, 32'hA5A5_A5A5, 32'd0, 2'b00, 2'b00);
      drive_op(3'd1, 32'd12345, 32'd678, 2'b00, 2'b00);
      got_done = 1'b0;
      cyc();
      bus.start_i = 1'b0;
      for (int n = 1; n < 10; n++) begin
         got_done |= bus.done_o;
         cyc();
      end
      bus.flush_i = 1'b1;
      #1;
      chk("flush_stall10", bus.stall_o, 1'b1);
      cyc();
      bus.flush_i = 1'b0;
      #1;
      chk("flush_busy11", bus.busy_o, 1'b0);
      chk("flush_stall11", bus.stall_o, 1'b0);
      for (int n = 0; n < 40; n++) begin
         got_done |= bus.done_o;
         cyc();
      end
      chk("flush_no_done", got_done, 1'b0);
      chk("flush_lo", bus.lo_o, 32'hA5A5_A5A5);

      // start with flush in IDLE is not accepted
      drive_op(3'd5, 32'h1111_2222, 32'd0, 2'b00, 2'b00);
      bus.flush_i = 1'b1;
      #1;
      chk("flush_idle_stall", bus.stall_o, 1'b0);
      cyc();
      idle_inputs();
      #1;
      chk("flush_idle_hi", bus.hi_o, m_hi);
      drive_op(3'd1, 32'd7, 32'd9, 2'b00, 2'b00);
      bus.flush_i = 1'b1;
      cyc();
      idle_inputs();
      #1;
      chk("flush_idle_mul", bus.busy_o, 1'b0);

      // Flush in FIN suppresses the write
      drive_op(3'd2, 32'd100, 32'd200, 2'b00, 2'b00);
      cyc();
      bus.start_i = 1'b0;
      repeat (XLEN) cyc();
      chk("fin_done_pre", bus.done_o, 1'b1);
      bus.flush_i = 1'b1;
      #1;
      chk("fin_done_flush", bus.done_o, 1'b0);
      cyc();
      bus.flush_i = 1'b0;
      #1;
      chk("fin_hi", bus.hi_o, m_hi);
      chk("fin_lo", bus.lo_o, m_lo);

      for (int i = 0; i < 40; i++) begin
         op = 3'($urandom_range(1, 6));
         fa = 2'($urandom_range(0, 3));
         fb = 2'($urandom_range(0, 3));
         if (fa == fb && (fa == 2'b01 || fa == 2'b10)) fb = 2'b11;
         run_op($sformatf("rnd%0d_op%0d", i, op), op, pick_val(), pick_val(), fa, fb);
      end

      // Reset in the middle of a divide clears everything at once
      drive_op(3'd3, 32'd1000, 32'd7, 2'b00, 2'b00);
      cyc();
      bus.start_i = 1'b0;
      repeat (19) cyc();
      rst = 1'b1;
      #1;
      chk("rstmid_busy", bus.busy_o, 1'b0);
      chk("rstmid_stall", bus.stall_o, 1'b0);
      chk("rstmid_done", {bus.done_o, bus.div0_o}, 2'b00);
      chk("rstmid_hilo", {bus.hi_o, bus.lo_o}, 64'd0);
      cyc();
      rst = 1'b0;
      m_hi = '0;
      m_lo = '0;
      run_op("post_rst", 3'd1, 32'd6, 32'hFFFF_FFF9, 2'b00, 2'b00);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ex_mdu.md
# ex_mdu

Parametrised execute-stage multiply/divide unit for the pipelined CPU. It sits beside the EX-stage ALU and receives the same decoded operands. It applies its own MEM/WB forwarding muxes, runs iterative signed and unsigned multiply/divide, and holds the HI/LO architectural registers. While an operation is in flight it stalls the pipeline front end, which gives MFHI/MFLO in ID interlocked values.

## Interface
- XLEN, 32: operand/HI/LO width; even, ≥8
- CW, 6: iteration-counter width; must satisfy 2^CW > XLEN
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  asynchronous, active-high reset
- start_i  in  1  EX holds a valid MDU op this cycle
- op_i  in  3  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 NONE
- rs_i, rt_i  in  XLEN  register-file operands
- mem_data_i, wb_data_i  in  XLEN  forwarding sources
- fwd_a_i, fwd_b_i  in  2  00 reg, 01 WB, 10 MEM, 11 reg
- flush_i  in  1  abort in-flight op
- stall_o  out  1  hold IF/ID/EX
- busy_o  out  1  state ≠ IDLE
- done_o  out  1  one-cycle pulse; HI/LO written at this edge
- div0_o  out  1  pulses with done_o on divide by zero
- hi_o, lo_o  out  XLEN  HI/LO register contents

## Operation
- Operands after the forwarding muxes: a = fwd(rs_i, fwd_a_i), b = fwd(rt_i, fwd_b_i).
- FSM states are IDLE, MUL, DIV and FIN.
- IDLE transitions:
  - start_i with MULT/MULTU → MUL.
  - start_i with DIV/DIVU → DIV.
  - Both latch a, b and the signedness. Signed ops store magnitudes plus sign bits.
  - MTHI/MTLO write a into HI/LO at the accepting edge and stay in IDLE.
- MUL: radix-2 shift-add over XLEN iterations on unsigned magnitudes into a 2·XLEN accumulator. After the last iteration → FIN.
- DIV: restoring division, one quotient bit per cycle, XLEN iterations. After the last iteration → FIN.
- FIN: sign correction, then the write.
  - Product is negated if sa^sb.
  - Quotient is negated if sa^sb. Remainder takes the sign of the dividend.
  - Write {HI,LO} = product, or HI = remainder, LO = quotient.
  - done_o = 1. Next state → IDLE.
- Divide by zero: HI = dividend as issued, LO = all ones. div0_o = 1 in FIN. The full latency is kept.
- Signed overflow (MIN / −1): LO = MIN, HI = 0.
- start_i while busy_o is ignored, including MTHI/MTLO.
- flush_i:
  - In any non-IDLE state → IDLE next edge. HI/LO are unchanged and there is no done_o.
  - flush_i with start_i in IDLE: the op is not accepted.
  - flush_i in FIN: the write is suppressed.
- Reset: state IDLE; HI = LO = 0; counter 0; stall_o, busy_o, done_o, div0_o = 0.

## Timing
- Accept edge is cycle 0. Iterations run in cycles 1..XLEN. FIN is cycle XLEN+1. New HI/LO are visible from cycle XLEN+2.
- stall_o = (IDLE & start_i & op∈{1..4} & !flush_i) | busy_o.
  - It is combinational, so it holds from cycle 0 through cycle XLEN+1.
  - It is low in cycle XLEN+2.
- MTHI/MTLO have single-cycle latency and no stall. The value is visible the next cycle.
- hi_o/lo_o are direct register outputs with no bypass.

## Configuration
- EX_MDU_DIV_EN:
  - Defined: DIV/DIVU behave as above.
  - Undefined: the divider datapath is removed. DIV/DIVU go IDLE→FIN in one cycle with HI/LO unchanged and div0_o pulsed as an illegal-op flag. MULT and MT* are unaffected.

## Structure
- Package ex_mdu_pkg holds:
  - the op_i encoding enum;
  - the FSM state enum;
  - the forwarding-select constants (FWD_REG, FWD_WB, FWD_MEM).
- Sub-module mdu_div_step is the natural split: one combinational restoring-divide step (partial remainder, divisor → next remainder, quotient bit). It is instantiated once under EX_MDU_DIV_EN.

## Test plan
Test plan values use XLEN=32.
- MULT a=0xFFFFFFFE, b=3 → stall_o for cycles 0–33, done_o in cycle 33; HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- MULTU with the same operands → HI=0x00000002, LO=0xFFFFFFFA, latency identical.
- DIV a=−7, b=2 with fwd_a_i=10 (mem_data_i=−7, rs_i=5) → LO=0xFFFFFFFD, HI=0xFFFFFFFF; confirms MEM forwarding.
- DIVU a=0x1234, b=0 → HI=0x1234, LO=0xFFFFFFFF; div0_o and done_o together in cycle 33. Without EX_MDU_DIV_EN: done_o in cycle 1, HI/LO unchanged.
- MTLO 0xA5A5A5A5, then MULT started and flushed at cycle 10 → state IDLE at cycle 11, no done_o, LO still 0xA5A5A5A5, stall_o low from cycle 11.
- Reset asserted in cycle 20 of a DIV → all outputs and HI/LO 0 immediately. start_i during busy is ignored.
